// File: rtl/voice_sched_pkg.sv
// Shared defaults and FSM encoding for the voice phase scheduler.
// Optional per-voice phase sync is enabled by defining VOICE_SYNC_EN.
package voice_sched_pkg;

  localparam int unsigned PHASE_W_DEF    = 17;
  localparam int unsigned NUM_VOICES_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/voice_tuning_regfile.sv
// Per-voice tuning word and phase storage: synchronous writes, asynchronous read by slot index.
module voice_tuning_regfile
  import voice_sched_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned PHASE_W    = PHASE_W_DEF,
  parameter int unsigned VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tune_we,
  input  logic [VIDX_W-1:0]  tune_idx,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               phase_we,
  input  logic [VIDX_W-1:0]  phase_idx,
  input  logic [PHASE_W-1:0] phase_word,
  input  logic [VIDX_W-1:0]  rd_idx,
  output logic [PHASE_W-1:0] tune_rd_c,
  output logic [PHASE_W-1:0] phase_rd_c
);

  logic [PHASE_W-1:0] tuning [NUM_VOICES];
  logic [PHASE_W-1:0] phase  [NUM_VOICES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        tuning[i] <= '0;
        phase[i]  <= '0;
      end
    end else begin
      if (tune_we) tuning[tune_idx] <= tune_word;
      if (phase_we) phase[phase_idx] <= phase_word;
    end
  end

  assign tune_rd_c  = tuning[rd_idx];
  assign phase_rd_c = phase[rd_idx];

endmodule

// File: rtl/voice_phase_scheduler.sv
// Shares one external adder between NUM_VOICES phase accumulators, one voice per cycle per tick.
// Define VOICE_SYNC_EN to add the voice_sync input (pending per-voice phase reset).
module voice_phase_scheduler
  import voice_sched_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned PHASE_W    = PHASE_W_DEF,
  parameter int unsigned VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  cfg_we,
  input  logic [VIDX_W-1:0]     cfg_voice,
  input  logic [PHASE_W-1:0]    cfg_word,
  input  logic [NUM_VOICES-1:0] voice_en,
`ifdef VOICE_SYNC_EN
  input  logic [NUM_VOICES-1:0] voice_sync,
`endif
  input  logic                  overrun_clr,
  output logic [PHASE_W-1:0]    add_a,
  output logic [PHASE_W-1:0]    add_b,
  output logic                  add_cin,
  input  logic [PHASE_W-1:0]    add_sum,
  input  logic                  add_cout,
  output logic [PHASE_W-1:0]    phase_out,
  output logic [VIDX_W-1:0]     phase_voice,
  output logic                  phase_valid,
  output logic                  wrap_out,
  output logic                  round_done,
  output logic                  busy,
  output logic                  tick_overrun
);

  localparam int unsigned LAST_IDX = NUM_VOICES - 1;

  sched_state_e       state;
  logic [VIDX_W-1:0]  idx;

  logic               start_c;
  logic               last_c;
  logic               advance_c;
  logic               cfg_ok_c;
  logic               slot_en_c;
  logic               sync_hit_c;
  logic               phase_we_c;
  logic [VIDX_W-1:0]  rd_idx_c;
  logic [PHASE_W-1:0] tune_rd_c;
  logic [PHASE_W-1:0] phase_rd_c;
  logic [PHASE_W-1:0] tune_fwd_c;
  logic [PHASE_W-1:0] new_phase_c;

  assign add_cin = 1'b0;

  // Operands for the next slot are registered one cycle ahead; a tuning write
  // landing on that same edge is forwarded so it still applies this round.
  always_comb begin
    start_c     = (state == IDLE) && sample_tick;
    last_c      = (state == RUN) && (32'(idx) == LAST_IDX);
    advance_c   = (state == RUN) && !last_c;
    cfg_ok_c    = cfg_we && (32'(cfg_voice) < NUM_VOICES);
    rd_idx_c    = '0;
    if (advance_c) rd_idx_c = idx + VIDX_W'(1);
    tune_fwd_c  = (cfg_ok_c && (cfg_voice == rd_idx_c)) ? cfg_word : tune_rd_c;
    slot_en_c   = (state == RUN) && voice_en[idx];
    new_phase_c = sync_hit_c ? '0 : add_sum;
    phase_we_c  = slot_en_c || sync_hit_c;
  end

`ifdef VOICE_SYNC_EN
  logic [NUM_VOICES-1:0] sync_pend;
  logic [NUM_VOICES-1:0] sync_clr_c;

  // Only a sync pending before the slot is consumed; one arriving in the slot waits a round.
  always_comb begin
    sync_clr_c = '0;
    if (state == RUN) sync_clr_c[idx] = sync_pend[idx];
    sync_hit_c = |sync_clr_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pend <= '0;
    end else begin
      sync_pend <= (sync_pend & ~sync_clr_c) | voice_sync;
    end
  end
`else
  always_comb begin
    sync_hit_c = 1'b0;
  end
`endif

  voice_tuning_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .VIDX_W     (VIDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .tune_we    (cfg_ok_c),
    .tune_idx   (cfg_voice),
    .tune_word  (cfg_word),
    .phase_we   (phase_we_c),
    .phase_idx  (idx),
    .phase_word (new_phase_c),
    .rd_idx     (rd_idx_c),
    .tune_rd_c  (tune_rd_c),
    .phase_rd_c (phase_rd_c)
  );

  // Round sequencer with registered adder operands and report outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      phase_out    <= '0;
      phase_voice  <= '0;
      phase_valid  <= 1'b0;
      wrap_out     <= 1'b0;
      round_done   <= 1'b0;
      busy         <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      if ((state == RUN) && sample_tick) begin
        tick_overrun <= 1'b1;
      end else if (overrun_clr) begin
        tick_overrun <= 1'b0;
      end

      if (start_c || advance_c) begin
        add_a <= phase_rd_c;
        add_b <= tune_fwd_c;
      end else begin
        add_a <= '0;
        add_b <= '0;
      end

      busy        <= start_c || advance_c;
      phase_valid <= slot_en_c;
      round_done  <= last_c;
      wrap_out    <= sync_hit_c || (slot_en_c && add_cout);

      if (state == RUN) begin
        phase_voice <= idx;
        phase_out   <= phase_we_c ? new_phase_c : add_a;
      end

      if (state == IDLE) begin
        if (sample_tick) begin
          state <= RUN;
          idx   <= '0;
        end
      end else begin
        if (last_c) begin
          state <= IDLE;
          idx   <= '0;
        end else begin
          idx <= idx + VIDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Scoreboard bench for voice_phase_scheduler with a behavioural 17-bit adder closing the loop.
module tb_voice_phase_scheduler;

  localparam int NV = 8;

  typedef struct {
    int         cyc;
    int         voice;
    logic [16:0] phase;
    logic       wrap;
  } rep_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic        cfg_we;
  logic [2:0]  cfg_voice;
  logic [16:0] cfg_word;
  logic [7:0]  voice_en;
`ifdef VOICE_SYNC_EN
  logic [7:0]  voice_sync;
`endif
  logic        overrun_clr;
  logic [16:0] add_a, add_b, add_sum, phase_out;
  logic        add_cin, add_cout;
  logic [2:0]  phase_voice;
  logic        phase_valid, wrap_out, round_done, busy, tick_overrun;
  logic [17:0] sum_full;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  rep_t exp_q[$];
  int   rd_q[$];
  logic [16:0] m_ph  [NV];
  logic [16:0] m_tun [NV];
  logic        m_sync[NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + 18'(add_cin);
  assign add_sum  = sum_full[16:0];
  assign add_cout = sum_full[17];

  voice_phase_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_word     (cfg_word),
    .voice_en     (voice_en),
`ifdef VOICE_SYNC_EN
    .voice_sync   (voice_sync),
`endif
    .overrun_clr  (overrun_clr),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .phase_out    (phase_out),
    .phase_voice  (phase_voice),
    .phase_valid  (phase_valid),
    .wrap_out     (wrap_out),
    .round_done   (round_done),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  // Monitor: every report and round_done is matched against the scoreboard.
  always @(negedge clk) begin
    rep_t e;
    int   rc;
    if (rst_n) begin
      if (phase_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_report cyc=%0d voice=%0d phase=%h", cyc, phase_voice, phase_out);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || phase_voice !== 3'(e.voice) || phase_out !== e.phase || wrap_out !== e.wrap) begin
            fails++;
            $display("FAIL report got cyc=%0d voice=%0d phase=%h wrap=%b, exp cyc=%0d voice=%0d phase=%h wrap=%b",
                     cyc, phase_voice, phase_out, wrap_out, e.cyc, e.voice, e.phase, e.wrap);
          end
        end
      end
      if (round_done) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_round_done cyc=%0d", cyc);
        end else begin
          rc = rd_q.pop_front();
          if (rc != cyc) begin
            fails++;
            $display("FAIL round_done_cycle got=%0d exp=%0d", cyc, rc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cfg(input int v, input logic [16:0] w);
    cfg_we    = 1'b1;
    cfg_voice = 3'(v);
    cfg_word  = w;
    step();
    cfg_we = 1'b0;
    m_tun[v] = w;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_ph[i]   = '0;
      m_tun[i]  = '0;
      m_sync[i] = 1'b0;
    end
  endtask

  // Issue a tick in the current cycle T and queue the round's expected reports.
  task automatic tick_round();
    int t;
    logic [17:0] s;
    t = cyc;
    for (int i = 0; i < NV; i++) begin
      if (m_sync[i]) begin
        m_ph[i]   = '0;
        m_sync[i] = 1'b0;
        if (voice_en[i]) exp_q.push_back('{t + 2 + i, i, 17'd0, 1'b1});
      end else if (voice_en[i]) begin
        s = {1'b0, m_ph[i]} + {1'b0, m_tun[i]};
        m_ph[i] = s[16:0];
        exp_q.push_back('{t + 2 + i, i, s[16:0], s[17]});
      end
    end
    rd_q.push_back(t + 1 + NV);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({add_a, add_b, add_cin, phase_out, phase_voice, phase_valid,
                wrap_out, round_done, busy, tick_overrun});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    cfg_voice   = '0;
    cfg_word    = '0;
    voice_en    = 8'hFF;
    overrun_clr = 1'b0;
`ifdef VOICE_SYNC_EN
    voice_sync  = '0;
`endif
    model_clear();

    idle(3);
    at_neg();
    chk("reset_outputs", out_vec(), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic round, latency and busy window
    cfg(0, 17'd1000);
    cfg(1, 17'h10000);
    cfg(2, 17'h1FFFF);
    cfg(3, 17'd2);
    at_neg();
    chk("busy_idle", 64'(busy), 64'd0);
    step();
    tick_round();
    for (int c = 1; c <= 9; c++) begin
      at_neg();
      chk($sformatf("busy_T+%0d", c), 64'(busy), 64'(c <= 8));
      step();
    end

    // Second tick 12 cycles after the first: voice 2 wraps
    idle(2);
    tick_round();
    idle(10);

    // Disabled voice keeps its slot and phase
    voice_en = 8'hFD;
    cfg(1, 17'd5);
    repeat (3) begin
      tick_round();
      idle(10);
    end
    voice_en = 8'hFF;
    tick_round();
    idle(10);

    // Overrun handling
    tick_round();
    idle(3);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    at_neg();
    chk("ovr_set", 64'(tick_overrun), 64'd1);
    chk("ovr_busy", 64'(busy), 64'd1);
    step();
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    at_neg();
    chk("ovr_set_wins", 64'(tick_overrun), 64'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    at_neg();
    chk("ovr_clr", 64'(tick_overrun), 64'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    at_neg();
    chk("ovr_last_run", 64'(tick_overrun), 64'd1);
    chk("idle_after_last", 64'(busy), 64'd0);
    tick_round();
    at_neg();
    chk("tick_accepted", 64'(busy), 64'd1);
    step();
    idle(9);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    at_neg();
    chk("ovr_clr_final", 64'(tick_overrun), 64'd0);
    step();

    // Tuning write during voice 3's own slot applies from the next round
    tick_round();
    idle(3);
    cfg(3, 17'd7);
    idle(9);
    tick_round();
    idle(10);

    // Reset in the middle of a round
    tick_round();
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_round", out_vec(), 64'd0);
    exp_q.delete();
    rd_q.delete();
    model_clear();
    idle(2);
    rst_n = 1'b1;
    step();
    at_neg();
    chk("after_reset_idle", out_vec(), 64'd0);
    step();
    cfg(0, 17'd1000);
    cfg(5, 17'h00123);
    tick_round();
    idle(10);

`ifdef VOICE_SYNC_EN
    // Sync pulse while idle resets voice 0 at its next slot
    voice_sync = 8'h01;
    step();
    voice_sync = '0;
    m_sync[0] = 1'b1;
    tick_round();
    idle(10);
    // Sync arriving during voice 0's slot waits for the following round
    tick_round();
    voice_sync = 8'h01;
    step();
    voice_sync = '0;
    m_sync[0] = 1'b1;
    idle(9);
    tick_round();
    idle(10);
`endif

    idle(4);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("round_done_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
